skid_buffer: RTL and testbench

Two-entry valid/ready register slice that registers the backward path. The existing pipeline stage registers data and valid but passes ready combinationally. This block breaks the ready path instead: `ready_o` comes straight from a flop, and a skid entry catches the word accepted in the cycle the consumer stalls. It sits between long-reach producers and consumers in the sprite/video datapath and chains freely with the forward pipeline stage. Throughput is full, one word per cycle.

---
 rtl/skid_buffer_pkg.sv | 17 +
 rtl/skid_buffer.sv | 88 ++++++++
 tb/tb_skid_buffer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid_buffer register slice: state encoding and occupancy width.
package skid_buffer_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // State encoding doubles as the word count held by the slice.
    function automatic logic [OCC_W-1:0] occupancy(input state_e s);
        return s;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready slice with a fully registered ready path (main + skid registers).
// Optional occupancy output `count_o` is built only when SKID_BUFFER_OCCUPANCY_EN is defined.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int width_p = 10
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
`ifdef SKID_BUFFER_OCCUPANCY_EN
    output logic [OCC_W-1:0]   count_o,
`endif
    input  logic               ready_i
);

    state_e             state, state_nxt;
    logic [width_p-1:0] main_q, skid_q;
    logic               accept, emit;
    logic               load_main, load_skid, main_from_skid;

    assign accept = valid_i & ready_o;
    assign emit   = valid_o & ready_i;
    assign data_o = main_q;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    // Consumer stalled this cycle: park the word taken on the registered ready.
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= EMPTY;
            valid_o <= 1'b0;
            ready_o <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
`ifdef SKID_BUFFER_OCCUPANCY_EN
            count_o <= '0;
`endif
        end else begin
            state   <= state_nxt;
            valid_o <= (state_nxt != EMPTY);
            ready_o <= (state_nxt != FULL);
`ifdef SKID_BUFFER_OCCUPANCY_EN
            count_o <= occupancy(state_nxt);
`endif
            if (load_main)
                main_q <= main_from_skid ? skid_q : data_i;
            if (load_skid)
                skid_q <= data_i;
        end
    end

endmodule

// File: tb/tb_skid_buffer.sv
// Directed/self-checking bench for skid_buffer (width 10 and width 1 instances).
module tb_skid_buffer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] data_i, data_o;
    logic       valid_i, ready_o, valid_o, ready_i;
    logic [0:0] d1_i, d1_o;
    logic       v1_i, r1_o, v1_o, r1_i;
`ifdef SKID_BUFFER_OCCUPANCY_EN
    logic [1:0] count, count1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    skid_buffer #(.width_p(10)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .valid_o(valid_o), .data_o(data_o),
`ifdef SKID_BUFFER_OCCUPANCY_EN
        .count_o(count),
`endif
        .ready_i(ready_i)
    );

    skid_buffer #(.width_p(1)) dut1 (
        .clk_i(clk), .reset_ni(reset_n),
        .data_i(d1_i), .valid_i(v1_i), .ready_o(r1_o),
        .valid_o(v1_o), .data_o(d1_o),
`ifdef SKID_BUFFER_OCCUPANCY_EN
        .count_o(count1),
`endif
        .ready_i(r1_i)
    );

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid_i = 1'b1; data_i = 10'h3FF; ready_i = 1'b1;
        v1_i = 1'b0; d1_i = 1'b0; r1_i = 1'b0;
        repeat (3) step();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready_o); end
        n_checks++; if (data_o !== 10'h000) begin n_fail++; $display("FAIL reset_data got %h want 000", data_o); end
`ifdef SKID_BUFFER_OCCUPANCY_EN
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
`endif
        reset_n = 1'b1;
        step();
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", ready_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got %b want 0", valid_o); end
        valid_i = 1'b0;
        step();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept got %b want 0", valid_o); end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1; data_i = 10'(i);
            step();
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== 10'(i) || ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%b d=%h r=%b want v=1 d=%h r=1", i, valid_o, data_o, ready_o, 10'(i));
            end
`ifdef SKID_BUFFER_OCCUPANCY_EN
            n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL stream_count got %0d want 1", count); end
`endif
        end
        valid_i = 1'b0;
        step();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", valid_o); end
    endtask

    task automatic test_stall_capture();
        ready_i = 1'b1; valid_i = 1'b1; data_i = 10'h0A1;
        step();
        ready_i = 1'b0; data_i = 10'h0A2;
        step();
        n_checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 10'h0A1) begin
            n_fail++;
            $display("FAIL stall_full got r=%b v=%b d=%h want r=0 v=1 d=0a1", ready_o, valid_o, data_o);
        end
`ifdef SKID_BUFFER_OCCUPANCY_EN
        n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL stall_count got %0d want 2", count); end
`endif
        data_i = 10'h0A3;
        step();
        n_checks++;
        if (ready_o !== 1'b0 || data_o !== 10'h0A1) begin
            n_fail++;
            $display("FAIL stall_hold got r=%b d=%h want r=0 d=0a1", ready_o, data_o);
        end
        ready_i = 1'b1;
        step();
        n_checks++;
        if (data_o !== 10'h0A2 || valid_o !== 1'b1 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release got d=%h v=%b r=%b want d=0a2 v=1 r=1", data_o, valid_o, ready_o);
        end
        step();
        n_checks++;
        if (data_o !== 10'h0A3 || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_third got d=%h v=%b want d=0a3 v=1", data_o, valid_o);
        end
        valid_i = 1'b0;
        step();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %b want 0", valid_o); end
    endtask

    task automatic test_random_backpressure();
        logic [9:0] q[$];
        logic [9:0] exp_d, prev_d;
        logic       hold_prev = 1'b0;
        int         emitted = 0;
        for (int c = 0; c < 10000; c++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            data_i  = 10'($urandom);
            #1;
            if (hold_prev) begin
                n_checks++;
                if (data_o !== prev_d) begin n_fail++; $display("FAIL rand_stable got %h want %h", data_o, prev_d); end
            end
            if (valid_o && ready_i) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra got %h want none", data_o);
                end else begin
                    exp_d = q.pop_front();
                    if (data_o !== exp_d) begin n_fail++; $display("FAIL rand_order got %h want %h", data_o, exp_d); end
                end
                emitted++;
            end
            if (valid_i && ready_o) q.push_back(data_i);
            hold_prev = valid_o & ~ready_i;
            prev_d    = data_o;
            step();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (valid_o) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_drain_extra got %h want none", data_o);
                end else begin
                    exp_d = q.pop_front();
                    if (data_o !== exp_d) begin n_fail++; $display("FAIL rand_drain got %h want %h", data_o, exp_d); end
                end
            end
            step();
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_lost got %0d want 0 words left", q.size()); end
        n_checks++; if (emitted < 1000) begin n_fail++; $display("FAIL rand_throughput got %0d want >=1000", emitted); end
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 10'h155;
        step();
        data_i = 10'h2AA;
        step();
        valid_i = 1'b0;
        n_checks++;
        if (ready_o !== 1'b0 || data_o !== 10'h155) begin
            n_fail++; $display("FAIL midrst_full got r=%b d=%h want r=0 d=155", ready_o, data_o);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o !== 10'h000) begin
            n_fail++; $display("FAIL midrst_async got v=%b r=%b d=%h want 0 0 000", valid_o, ready_o, data_o);
        end
`ifdef SKID_BUFFER_OCCUPANCY_EN
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", count); end
`endif
        ready_i = 1'b1;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (valid_o !== 1'b0 || data_o !== 10'h000) begin
                n_fail++; $display("FAIL midrst_after_%0d got v=%b d=%h want v=0 d=000", c, valid_o, data_o);
            end
        end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", ready_o); end
    endtask

    task automatic test_width1();
        logic send_bit = 1'b0;
        logic exp_bit  = 1'b0;
        int   got = 0;
        for (int c = 0; c < 300; c++) begin
            v1_i = 1'b1;
            d1_i = send_bit;
            r1_i = 1'($urandom_range(0, 1));
            #1;
            if (v1_o && r1_i) begin
                n_checks++;
                if (d1_o !== exp_bit) begin n_fail++; $display("FAIL w1_order_%0d got %b want %b", got, d1_o, exp_bit); end
                exp_bit = ~exp_bit;
                got++;
            end
            if (v1_i && r1_o) send_bit = ~send_bit;
            step();
        end
        v1_i = 1'b0;
        n_checks++; if (got < 50) begin n_fail++; $display("FAIL w1_progress got %0d want >=50", got); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_capture();
        test_random_backpressure();
        test_mid_reset();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
